// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus: decode fields and write-back port in, EX copies out.
// master = the decode/control side that drives ID and WB fields; slave = the stage.
interface id_ex_stage_if #(
  parameter int BUBBLE_CNT_W = 16
);
  logic                    mem_stall_i;
  logic                    flush_i;
  logic [31:0]             id_rs1_data_i;
  logic [31:0]             id_rs2_data_i;
  logic [31:0]             id_imm_i;
  logic [4:0]              id_rs1_addr_i;
  logic [4:0]              id_rs2_addr_i;
  logic [4:0]              id_rd_addr_i;
  logic [9:0]              id_funct_i;
  logic [1:0]              id_alu_op_i;
  logic                    id_alu_src_i;
  logic                    id_reg_write_i;
  logic                    id_mem_to_reg_i;
  logic                    id_mem_read_i;
  logic                    id_mem_write_i;
  logic                    wb_reg_write_i;
  logic [4:0]              wb_rd_addr_i;
  logic [31:0]             wb_data_i;
  logic [31:0]             ex_rs1_data_o;
  logic [31:0]             ex_rs2_data_o;
  logic [31:0]             ex_imm_o;
  logic [4:0]              ex_rs1_addr_o;
  logic [4:0]              ex_rs2_addr_o;
  logic [4:0]              ex_rd_addr_o;
  logic [9:0]              ex_funct_o;
  logic [1:0]              ex_alu_op_o;
  logic                    ex_alu_src_o;
  logic                    ex_reg_write_o;
  logic                    ex_mem_to_reg_o;
  logic                    ex_mem_read_o;
  logic                    ex_mem_write_o;
  logic                    ex_valid_o;
  logic                    hazard_stall_o;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_o;

  modport master (
    output mem_stall_i, flush_i,
    output id_rs1_data_i, id_rs2_data_i, id_imm_i,
    output id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
    output id_funct_i, id_alu_op_i, id_alu_src_i, id_reg_write_i,
    output id_mem_to_reg_i, id_mem_read_i, id_mem_write_i,
    output wb_reg_write_i, wb_rd_addr_i, wb_data_i,
    input  ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
    input  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
    input  ex_funct_o, ex_alu_op_o, ex_alu_src_o, ex_reg_write_o,
    input  ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o,
    input  ex_valid_o, hazard_stall_o, bubble_cnt_o
  );

  modport slave (
    input  mem_stall_i, flush_i,
    input  id_rs1_data_i, id_rs2_data_i, id_imm_i,
    input  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
    input  id_funct_i, id_alu_op_i, id_alu_src_i, id_reg_write_i,
    input  id_mem_to_reg_i, id_mem_read_i, id_mem_write_i,
    input  wb_reg_write_i, wb_rd_addr_i, wb_data_i,
    output ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
    output ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
    output ex_funct_o, ex_alu_op_o, ex_alu_src_o, ex_reg_write_o,
    output ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o,
    output ex_valid_o, hazard_stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through, load-use hazard detection,
// bubble insertion on flush/hazard, cache-stall freeze and a saturating bubble count.
module id_ex_stage #(
  parameter int BUBBLE_CNT_W = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [9:0]  funct;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        valid;
  } ex_fields_t;

  localparam logic [BUBBLE_CNT_W-1:0] CNT_MAX = '1;

  ex_fields_t              ex_q;
  ex_fields_t              id_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;
  logic                    hazard;

  // Assemble the next EX contents from ID, bypassing the WB write that the
  // register file has not yet made visible on its read ports.
  always_comb begin
    // NOTE: default every field first so no path leaves a field unassigned (no latch).
    id_d            = '0;
    id_d.rs1_data   = bus.id_rs1_data_i;
    id_d.rs2_data   = bus.id_rs2_data_i;
    if (bus.wb_reg_write_i && (bus.wb_rd_addr_i != 5'd0) &&
        (bus.wb_rd_addr_i == bus.id_rs1_addr_i))
      id_d.rs1_data = bus.wb_data_i;
    if (bus.wb_reg_write_i && (bus.wb_rd_addr_i != 5'd0) &&
        (bus.wb_rd_addr_i == bus.id_rs2_addr_i))
      id_d.rs2_data = bus.wb_data_i;
    id_d.imm        = bus.id_imm_i;
    id_d.rs1_addr   = bus.id_rs1_addr_i;
    id_d.rs2_addr   = bus.id_rs2_addr_i;
    id_d.rd_addr    = bus.id_rd_addr_i;
    id_d.funct      = bus.id_funct_i;
    id_d.alu_op     = bus.id_alu_op_i;
    id_d.alu_src    = bus.id_alu_src_i;
    id_d.reg_write  = bus.id_reg_write_i;
    id_d.mem_to_reg = bus.id_mem_to_reg_i;
    id_d.mem_read   = bus.id_mem_read_i;
    id_d.mem_write  = bus.id_mem_write_i;
    id_d.valid      = 1'b1;
  end

  // Load in EX whose destination is read by ID: the loaded value is not ready yet.
  // The rs2 compare is unconditional; a false stall on an unused rs2 is harmless.
  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) &&
                  ((ex_q.rd_addr == bus.id_rs1_addr_i) ||
                   (ex_q.rd_addr == bus.id_rs2_addr_i));

  // Stage register: cache stall freezes, flush or hazard loads a counted bubble,
  // otherwise the ID instruction advances.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.mem_stall_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ex_q         <= ex_q;
      bubble_cnt_q <= bubble_cnt_q;
    end else if (bus.flush_i || hazard) begin
      ex_q <= '0;
      if (bubble_cnt_q != CNT_MAX)
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end else begin
      ex_q <= id_d;
    end
  end

  assign bus.ex_rs1_data_o   = ex_q.rs1_data;
  assign bus.ex_rs2_data_o   = ex_q.rs2_data;
  assign bus.ex_imm_o        = ex_q.imm;
  assign bus.ex_rs1_addr_o   = ex_q.rs1_addr;
  assign bus.ex_rs2_addr_o   = ex_q.rs2_addr;
  assign bus.ex_rd_addr_o    = ex_q.rd_addr;
  assign bus.ex_funct_o      = ex_q.funct;
  assign bus.ex_alu_op_o     = ex_q.alu_op;
  assign bus.ex_alu_src_o    = ex_q.alu_src;
  assign bus.ex_reg_write_o  = ex_q.reg_write;
  assign bus.ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign bus.ex_mem_read_o   = ex_q.mem_read;
  assign bus.ex_mem_write_o  = ex_q.mem_write;
  assign bus.ex_valid_o      = ex_q.valid;
  assign bus.hazard_stall_o  = hazard;
  assign bus.bubble_cnt_o    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, write-through, load-use,
// cache stall with flush, bubble counting and counter saturation at width 4.
module tb_id_ex_stage;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic rst_b = 1'b0;

  int total = 0;
  int bad   = 0;

  id_ex_stage_if #(.BUBBLE_CNT_W(16)) bus ();
  id_ex_stage_if #(.BUBBLE_CNT_W(4))  bus_b ();

  id_ex_stage #(.BUBBLE_CNT_W(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  id_ex_stage #(.BUBBLE_CNT_W(4)) dut_b (
    .clk_i (clk_i),
    .rst_i (rst_b),
    .bus   (bus_b.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rda,
                        input logic [31:0] rs1d, input logic [31:0] rs2d,
                        input logic mem_read, input logic reg_write);
    bus.id_rs1_addr_i   = rs1a;
    bus.id_rs2_addr_i   = rs2a;
    bus.id_rd_addr_i    = rda;
    bus.id_rs1_data_i   = rs1d;
    bus.id_rs2_data_i   = rs2d;
    bus.id_mem_read_i   = mem_read;
    bus.id_mem_to_reg_i = mem_read;
    bus.id_alu_src_i    = mem_read;
    bus.id_reg_write_i  = reg_write;
  endtask

  initial begin
    bus.mem_stall_i    = 1'b0;
    bus.flush_i        = 1'b0;
    bus.id_imm_i       = 32'h0000_0ABC;
    bus.id_funct_i     = 10'h000;
    bus.id_alu_op_i    = 2'b10;
    bus.id_mem_write_i = 1'b0;
    bus.wb_reg_write_i = 1'b0;
    bus.wb_rd_addr_i   = 5'd0;
    bus.wb_data_i      = 32'h0;
    set_id(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);

    bus_b.mem_stall_i     = 1'b0;
    bus_b.flush_i         = 1'b1;
    bus_b.id_rs1_data_i   = 32'h0;
    bus_b.id_rs2_data_i   = 32'h0;
    bus_b.id_imm_i        = 32'h0;
    bus_b.id_rs1_addr_i   = 5'd0;
    bus_b.id_rs2_addr_i   = 5'd0;
    bus_b.id_rd_addr_i    = 5'd0;
    bus_b.id_funct_i      = 10'h0;
    bus_b.id_alu_op_i     = 2'b0;
    bus_b.id_alu_src_i    = 1'b0;
    bus_b.id_reg_write_i  = 1'b0;
    bus_b.id_mem_to_reg_i = 1'b0;
    bus_b.id_mem_read_i   = 1'b0;
    bus_b.id_mem_write_i  = 1'b0;
    bus_b.wb_reg_write_i  = 1'b0;
    bus_b.wb_rd_addr_i    = 5'd0;
    bus_b.wb_data_i       = 32'h0;

    // Reset state
    #1;
    check("rst_valid", 32'(bus.ex_valid_o), 0);
    check("rst_cnt", 32'(bus.bubble_cnt_o), 0);
    check("rst_hazard", 32'(bus.hazard_stall_o), 0);
    #1 rst_i = 1'b1;

    // Pass-through: add x3, x1, x2
    set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b0, 1'b1);
    tick();
    check("pt_rs1", bus.ex_rs1_data_o, 32'h11);
    check("pt_rs2", bus.ex_rs2_data_o, 32'h22);
    check("pt_rd", 32'(bus.ex_rd_addr_o), 3);
    check("pt_valid", 32'(bus.ex_valid_o), 1);
    check("pt_regw", 32'(bus.ex_reg_write_o), 1);
    check("pt_imm", bus.ex_imm_o, 32'h0000_0ABC);
    check("pt_aluop", 32'(bus.ex_alu_op_o), 2);

    // Write-through: WB x1 = 0xDEAD, ID reads stale 0
    bus.wb_reg_write_i = 1'b1;
    bus.wb_rd_addr_i   = 5'd1;
    bus.wb_data_i      = 32'hDEAD;
    set_id(5'd1, 5'd2, 5'd4, 32'h0, 32'h22, 1'b0, 1'b1);
    tick();
    check("wt_rs1", bus.ex_rs1_data_o, 32'hDEAD);
    check("wt_rs2_untouched", bus.ex_rs2_data_o, 32'h22);
    // rs2 path of the bypass
    set_id(5'd2, 5'd1, 5'd4, 32'h33, 32'h0, 1'b0, 1'b1);
    tick();
    check("wt_rs2", bus.ex_rs2_data_o, 32'hDEAD);
    check("wt_rs1_untouched", bus.ex_rs1_data_o, 32'h33);
    // WB to x0 must not bypass
    bus.wb_rd_addr_i = 5'd0;
    set_id(5'd0, 5'd2, 5'd4, 32'h55, 32'h22, 1'b0, 1'b1);
    tick();
    check("wt_x0_stale", bus.ex_rs1_data_o, 32'h55);
    bus.wb_reg_write_i = 1'b0;

    // Load-use: lw x5 then add x6, x5, x7
    set_id(5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 1'b1, 1'b1);
    tick();
    check("lu_lw_in_ex", 32'(bus.ex_mem_read_o), 1);
    set_id(5'd5, 5'd7, 5'd6, 32'h100, 32'h200, 1'b0, 1'b1);
    #1;
    check("lu_hazard", 32'(bus.hazard_stall_o), 1);
    tick();
    check("lu_bubble_valid", 32'(bus.ex_valid_o), 0);
    check("lu_bubble_regw", 32'(bus.ex_reg_write_o), 0);
    check("lu_bubble_imm", bus.ex_imm_o, 0);
    check("lu_cnt", 32'(bus.bubble_cnt_o), 1);
    check("lu_hazard_clear", 32'(bus.hazard_stall_o), 0);
    tick();
    check("lu_dep_valid", 32'(bus.ex_valid_o), 1);
    check("lu_dep_rd", 32'(bus.ex_rd_addr_o), 6);
    check("lu_dep_rs1", bus.ex_rs1_data_o, 32'h100);
    check("lu_cnt_hold", 32'(bus.bubble_cnt_o), 1);

    // Cache stall with flush and a pending rs2-only hazard
    set_id(5'd2, 5'd0, 5'd8, 32'h2000, 32'h0, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 5'd8, 5'd9, 32'h0, 32'h77, 1'b0, 1'b1);
    bus.mem_stall_i = 1'b1;
    bus.flush_i     = 1'b1;
    #1;
    check("cs_hazard_rs2", 32'(bus.hazard_stall_o), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cs_hold_valid", 32'(bus.ex_valid_o), 1);
      check("cs_hold_rd", 32'(bus.ex_rd_addr_o), 8);
      check("cs_hold_cnt", 32'(bus.bubble_cnt_o), 1);
    end
    bus.mem_stall_i = 1'b0;
    tick();
    check("cs_rel_valid", 32'(bus.ex_valid_o), 0);
    check("cs_rel_cnt_once", 32'(bus.bubble_cnt_o), 2);
    bus.flush_i = 1'b0;
    tick();
    check("cs_after_valid", 32'(bus.ex_valid_o), 1);
    check("cs_after_rd", 32'(bus.ex_rd_addr_o), 9);
    check("cs_after_cnt", 32'(bus.bubble_cnt_o), 2);

    // Three flushes bring the counter to 5, then a real instruction enters
    bus.flush_i = 1'b1;
    tick();
    check("fl_valid", 32'(bus.ex_valid_o), 0);
    check("fl_cnt", 32'(bus.bubble_cnt_o), 3);
    tick();
    tick();
    bus.flush_i = 1'b0;
    set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b0, 1'b1);
    tick();
    check("pre_rst_valid", 32'(bus.ex_valid_o), 1);
    check("pre_rst_cnt", 32'(bus.bubble_cnt_o), 5);

    // Asynchronous reset mid-cycle, observed before the next edge
    #2 rst_i = 1'b0;
    #1;
    check("arst_valid", 32'(bus.ex_valid_o), 0);
    check("arst_cnt", 32'(bus.bubble_cnt_o), 0);
    check("arst_rs1", bus.ex_rs1_data_o, 0);
    check("arst_rd", 32'(bus.ex_rd_addr_o), 0);
    tick();
    rst_i = 1'b1;
    tick();
    check("post_rst_valid", 32'(bus.ex_valid_o), 1);
    check("post_rst_rs2", bus.ex_rs2_data_o, 32'h22);
    check("post_rst_cnt", 32'(bus.bubble_cnt_o), 0);

    // Saturation at width 4: flush held high from release
    rst_b = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", 32'(bus_b.bubble_cnt_o), 14);
    tick();
    check("sat_15", 32'(bus_b.bubble_cnt_o), 15);
    tick();
    tick();
    check("sat_17_nowrap", 32'(bus_b.bubble_cnt_o), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute for the five-stage RISC-V core. It captures operands and controls from ID, with write-back write-through so `rs*_data_o` are the current register values. It detects load-use hazards, inserts bubbles, and honours cache stalls and flushes. Its `ex_rs1_data_o` and `ex_rs2_data_o` are the `00` (no-forward) inputs of the EX forwarding muxes.

## Interface

- `BUBBLE_CNT_W`, default 16: width of the saturating bubble counter.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous reset, active-low.
- `mem_stall_i` in 1: data-cache miss stall; freezes the stage.
- `flush_i` in 1: kill the instruction entering EX; insert a bubble.
- `id_rs1_data_i`, `id_rs2_data_i` in 32: register-file read data.
- `id_imm_i` in 32: sign-extended immediate.
- `id_rs1_addr_i`, `id_rs2_addr_i`, `id_rd_addr_i` in 5: register addresses.
- `id_funct_i` in 10: {funct7, funct3}.
- `id_alu_op_i` in 2: ALU operation class.
- `id_alu_src_i`, `id_reg_write_i`, `id_mem_to_reg_i`, `id_mem_read_i`, `id_mem_write_i` in 1: control bits.
- `wb_reg_write_i` in 1: WB-stage register write enable.
- `wb_rd_addr_i` in 5: WB-stage destination register.
- `wb_data_i` in 32: WB-stage write data.
- `ex_*_o` out (same widths as the corresponding `id_*_i`): registered copies of every `id_*_i` field.
- `ex_valid_o` out 1: EX holds a real instruction.
- `hazard_stall_o` out 1: combinational; hold PC and IF/ID this cycle.
- `bubble_cnt_o` out BUBBLE_CNT_W: saturating count of inserted bubbles.

## Operation

- **Write-through.** The captured rs1 value is `wb_data_i` when `wb_reg_write_i` is 1, `wb_rd_addr_i` is nonzero, and `wb_rd_addr_i == id_rs1_addr_i`. Otherwise it is `id_rs1_data_i`. rs2 uses the same rule.
- **Load-use hazard.** `hazard_stall_o = ex_valid_o & ex_mem_read_o & (ex_rd_addr_o != 0) & (ex_rd_addr_o == id_rs1_addr_i | ex_rd_addr_o == id_rs2_addr_i)`. The rs2 compare applies even when rs2 is unused, so a false stall is acceptable.
- **Bubble.** Every `ex_*` output and `ex_valid_o` become 0, so the bubble is a NOP with rd = x0.
- **Per-edge priority, highest first:**
  1. `mem_stall_i = 1`: hold all registers, including `bubble_cnt_o`.
  2. `flush_i = 1`: load a bubble; count it.
  3. `hazard_stall_o = 1`: load a bubble; count it.
  4. Otherwise: load the ID fields (with write-through applied) and set `ex_valid_o = 1`.
- **Bubble counter.** Increments by 1 per counted bubble and saturates at all-ones; it does not wrap.
- **hazard_stall_o under stall.** It is still driven from the current EX contents while `mem_stall_i` is 1. Upstream stages are frozen by `mem_stall_i` anyway.

## Timing

- Reset: every `ex_*` output, `ex_valid_o` and `bubble_cnt_o` go to 0 immediately while `rst_i` is low. `hazard_stall_o` is therefore 0 during reset.
- Latency: ID to `ex_*` is one cycle.
- Load-use: the dependent instruction reaches EX exactly one cycle late, with one bubble in between.
- `hazard_stall_o` is valid in the same cycle it is needed; there is no registered delay on it.
- Reset deasserting mid-stall: the first edge after release acts on the current inputs. No state is held over from before reset.
- `flush_i` and `hazard_stall_o` high together: a single bubble, counted once.

## Test plan

- **Reset:** drive `rst_i` low mid-run with `ex_valid_o = 1` and `bubble_cnt_o = 5` → all outputs 0 asynchronously, before the next clock edge.
- **Pass-through:** ID add x3,x1,x2 with rs1 data `0x11`, rs2 data `0x22` → next cycle `ex_rs1_data_o = 0x11`, `ex_rs2_data_o = 0x22`, `ex_rd_addr_o = 3`, `ex_valid_o = 1`.
- **Write-through:** WB writes x1 = `0xDEAD` while ID reads x1 with stale `0x0` → `ex_rs1_data_o = 0xDEAD`. Repeat with `wb_rd_addr_i = 0` → stale value kept.
- **Load-use:** lw x5 in EX, ID reads x5 → `hazard_stall_o = 1`. Next cycle: `ex_valid_o = 0`, `ex_reg_write_o = 0`, `bubble_cnt_o` incremented by 1. Same ID instruction enters EX one cycle later.
- **Cache stall:** `mem_stall_i = 1` for 4 cycles with `flush_i = 1` and a pending hazard → outputs and counter unchanged. On release, a single bubble is inserted.
- **Saturation:** with `BUBBLE_CNT_W = 4`, force 17 bubbles → `bubble_cnt_o = 15`, no wrap.
